// File: rtl/mbus_axi_rd_master.sv
// mbus_axi_rd_master
//   Serves the frame reader's mbus read request with one fixed-length AXI4
//   read burst to the DDR controller. Beats come back on o_mbus_rdata with a
//   one-cycle o_mbus_rdata_rq strobe each. rsel/rbusy frame the whole
//   transaction. A cooldown follows every transaction so the client can
//   see rbusy fall before its next request is sampled.
//   Single client, one burst outstanding, one clock domain.
//
// Optional feature: define MBUS_RD_TIMEOUT_EN to enable a watchdog in AR/RD.
//   The watchdog sets o_err and forces the transaction to finish after
//   TIMEOUT cycles without a handshake.
//
// Ports
//   i_axi_aclk, i_rst        clock, asynchronous active-high reset
//   i_mbus_rrq/raddr/rready  client request, burst address, client FIFO room
//   o_mbus_rdata/rdata_rq    returned beat and its strobe
//   o_mbus_rbusy/rsel        transaction framing / grant
//   o_axi_ar*, i_axi_arready AXI read address channel
//   i_axi_r*, o_axi_rready   AXI read data channel
//   o_err                    sticky error (bad rresp, rlast count, timeout)
module mbus_axi_rd_master #(
    parameter int MEM_DQ_WIDTH    = 16,
    parameter int BURST_LENGTH    = 8,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int BURST_BEATS     = 16,
    parameter int COOLDOWN        = 4,
    parameter int TIMEOUT         = 1024
) (
    input  logic                                   i_axi_aclk,
    input  logic                                   i_rst,
    input  logic                                   i_mbus_rrq,
    input  logic [CTRL_ADDR_WIDTH-1:0]             i_mbus_raddr,
    input  logic                                   i_mbus_rready,
    output logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0]   o_mbus_rdata,
    output logic                                   o_mbus_rdata_rq,
    output logic                                   o_mbus_rbusy,
    output logic                                   o_mbus_rsel,
    output logic [CTRL_ADDR_WIDTH-1:0]             o_axi_araddr,
    output logic [7:0]                             o_axi_arlen,
    output logic                                   o_axi_arvalid,
    input  logic                                   i_axi_arready,
    input  logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0]   i_axi_rdata,
    input  logic [1:0]                             i_axi_rresp,
    input  logic                                   i_axi_rlast,
    input  logic                                   i_axi_rvalid,
    output logic                                   o_axi_rready,
    output logic                                   o_err
);

    localparam int BW = $clog2(BURST_BEATS + 1);
    localparam int CW = $clog2(COOLDOWN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);
    localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT - 1);

`ifdef MBUS_RD_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_RD,
        S_DONE,
        S_COOL
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic [BW-1:0]   beat_nxt;
    logic [CW-1:0]   cool_cnt;
    logic [WW-1:0]   wd_cnt;

    assign beat_nxt    = beat_cnt + BW'(1);
    assign o_axi_arlen = 8'(BURST_BEATS - 1);

    always_ff @(posedge i_axi_aclk or posedge i_rst) begin
        if (i_rst) begin
            state           <= S_IDLE;
            beat_cnt        <= '0;
            cool_cnt        <= '0;
            wd_cnt          <= '0;
            o_mbus_rdata    <= '0;
            o_mbus_rdata_rq <= 1'b0;
            o_mbus_rbusy    <= 1'b0;
            o_mbus_rsel     <= 1'b0;
            o_axi_araddr    <= '0;
            o_axi_arvalid   <= 1'b0;
            o_axi_rready    <= 1'b0;
            o_err           <= 1'b0;
        end else begin
            // The beat strobe is a single-cycle pulse unless a beat lands.
            o_mbus_rdata_rq <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_mbus_rrq && i_mbus_rready) begin
                        o_axi_araddr  <= i_mbus_raddr;
                        o_axi_arvalid <= 1'b1;
                        o_mbus_rsel   <= 1'b1;
                        o_mbus_rbusy  <= 1'b1;
                        wd_cnt        <= '0;
                        state         <= S_AR;
                    end
                end
                S_AR: begin
                    // arvalid is always high here, so arready alone is the handshake.
                    if (i_axi_arready) begin
                        o_axi_arvalid <= 1'b0;
                        o_axi_rready  <= 1'b1;
                        beat_cnt      <= '0;
                        wd_cnt        <= '0;
                        state         <= S_RD;
                    end else if (WD_EN) begin
                        if (wd_cnt == WD_LIMIT) begin
                            o_err         <= 1'b1;
                            o_axi_arvalid <= 1'b0;
                            state         <= S_DONE;
                        end else begin
                            wd_cnt <= wd_cnt + WW'(1);
                        end
                    end
                end
                S_RD: begin
                    if (i_axi_rvalid) begin
                        o_mbus_rdata    <= i_axi_rdata;
                        o_mbus_rdata_rq <= 1'b1;
                        beat_cnt        <= beat_nxt;
                        wd_cnt          <= '0;
                        if (i_axi_rresp != 2'b00) o_err <= 1'b1;
                        // Finish on the first rlast; a missing rlast is forced
                        // to finish at the nominal burst length.
                        if (i_axi_rlast) begin
                            if (beat_nxt != LAST_BEAT) o_err <= 1'b1;
                            state <= S_DONE;
                        end else if (beat_nxt == LAST_BEAT) begin
                            o_err <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (WD_EN) begin
                        if (wd_cnt == WD_LIMIT) begin
                            o_err        <= 1'b1;
                            o_axi_rready <= 1'b0;
                            state        <= S_DONE;
                        end else begin
                            wd_cnt <= wd_cnt + WW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // One spare cycle so the last strobe precedes the rbusy fall.
                    o_mbus_rbusy <= 1'b0;
                    o_mbus_rsel  <= 1'b0;
                    o_axi_rready <= 1'b0;
                    cool_cnt     <= COOL_LOAD;
                    state        <= S_COOL;
                end
                S_COOL: begin
                    if (cool_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cool_cnt <= cool_cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbus_axi_rd_master.sv
module tb_mbus_axi_rd_master;

    localparam int DW    = 128;
    localparam int AW    = 28;
    localparam int BEATS = 16;
    localparam int COOL  = 4;
    localparam int TO    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          rrq;
    logic [AW-1:0] raddr;
    logic          rready;
    logic [DW-1:0] rd_data;
    logic          rd_rq;
    logic          rbusy;
    logic          rsel;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          axi_rready;
    logic          err;

    mbus_axi_rd_master #(
        .TIMEOUT(TO)
    ) dut (
        .i_axi_aclk     (clk),
        .i_rst          (rst),
        .i_mbus_rrq     (rrq),
        .i_mbus_raddr   (raddr),
        .i_mbus_rready  (rready),
        .o_mbus_rdata   (rd_data),
        .o_mbus_rdata_rq(rd_rq),
        .o_mbus_rbusy   (rbusy),
        .o_mbus_rsel    (rsel),
        .o_axi_araddr   (araddr),
        .o_axi_arlen    (arlen),
        .o_axi_arvalid  (arvalid),
        .i_axi_arready  (arready),
        .i_axi_rdata    (rdata),
        .i_axi_rresp    (rresp),
        .i_axi_rlast    (rlast),
        .i_axi_rvalid   (rvalid),
        .o_axi_rready   (axi_rready),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [AW-1:0] addr;
        int            ar_delay;
        int            gap_max;
        int            err_beat;
        int            last_beat;
        int            exp_pulses;
        logic          exp_err;
    } row_t;

    row_t rows[5];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: every strobe must carry the oldest beat the slave sent.
    always @(negedge clk) begin
        if (!rst && rd_rq) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_unexpected: got %0h expected no strobe", rd_data);
            end else begin
                chk("rdata_order", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic request(input logic [AW-1:0] a, output int lat);
        rrq    = 1'b1;
        rready = 1'b1;
        raddr  = a;
        lat    = 0;
        do begin
            tick();
            lat++;
        end while (arvalid !== 1'b1 && lat < 100);
        chk("req_arvalid", arvalid, 1);
        chk("req_rsel", rsel, 1);
        chk("req_rbusy", rbusy, 1);
        chk("req_araddr", araddr, a);
    endtask

    task automatic ar_phase(input int delay);
        logic [AW-1:0] a0;
        bit stable;
        a0     = araddr;
        stable = 1'b1;
        arready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tick();
            if (arvalid !== 1'b1 || araddr !== a0) stable = 1'b0;
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("ar_hold", stable, 1);
        chk("ar_drop", arvalid, 0);
        chk("rready_on", axi_rready, 1);
    endtask

    task automatic r_phase(input int nbeats, input int gap_max, input int err_beat,
                           input int last_beat, input int exp_pulses);
        bit strobe_ok;
        bit rr_ok;
        int g;
        logic [DW-1:0] d;
        strobe_ok = 1'b1;
        rr_ok     = 1'b1;
        pulses    = 0;
        for (int b = 1; b <= nbeats; b++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int k = 0; k < g; k++) begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                tick();
                if (rd_rq !== 1'b0) strobe_ok = 1'b0;
            end
            if (axi_rready !== 1'b1) rr_ok = 1'b0;
            d      = {$urandom(), $urandom(), $urandom(), $urandom()};
            rvalid = 1'b1;
            rdata  = d;
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == last_beat);
            exp_q.push_back(d);
            tick();
            if (rd_rq !== 1'b1) strobe_ok = 1'b0;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        chk("busy_after_last", rbusy, 1);
        tick();
        chk("busy_fall", rbusy, 0);
        chk("rsel_fall", rsel, 0);
        chk("rready_fall", axi_rready, 0);
        chk("strobe_after_end", rd_rq, 0);
        chk("pulse_count", pulses, exp_pulses);
        chk("strobe_timing", strobe_ok, 1);
        chk("rready_held", rr_ok, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic idle_wait();
        rrq = 1'b0;
        repeat (COOL + 4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int cnt;
        bit ok;
        logic [AW-1:0] a;

        rows[0] = '{28'h0000100, 0, 0, 0, 16, 16, 1'b0};
        rows[1] = '{28'h0000180, 7, 3, 0, 16, 16, 1'b0};
        rows[2] = '{28'h0000200, 2, 2, 5, 12, 12, 1'b1};
        rows[3] = '{28'h0000280, 1, 1, 0, 0, 16, 1'b1};
        rows[4] = '{28'h0000300, 0, 1, 0, 16, 16, 1'b1};

        rst     = 1'b1;
        rrq     = 1'b0;
        raddr   = '0;
        rready  = 1'b0;
        arready = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        repeat (3) tick();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rsel", rsel, 0);
        chk("rst_rbusy", rbusy, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_rdata_rq", rd_rq, 0);
        chk("rst_err", err, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_arlen", arlen, BEATS - 1);
        rst = 1'b0;
        tick();

        // Randomized clean bursts
        for (int n = 0; n < 6; n++) begin
            a = AW'($urandom_range(0, 4095)) << 7;
            request(a, lat);
            chk("rand_req_latency", lat, 1);
            rrq = 1'b0;
            ar_phase(int'($urandom_range(0, 5)));
            r_phase(BEATS, 3, 0, BEATS, BEATS);
            chk("rand_err", err, 0);
            idle_wait();
        end

        // Client FIFO not ready holds off the request
        rrq    = 1'b1;
        rready = 1'b0;
        raddr  = 28'h40;
        ok     = 1'b1;
        repeat (50) begin
            tick();
            if (arvalid !== 1'b0) ok = 1'b0;
        end
        chk("no_ar_without_rready", ok, 1);
        request(28'h40, lat);
        chk("rready_latency", lat, 1);
        rrq = 1'b0;
        ar_phase(0);
        r_phase(BEATS, 0, 0, BEATS, BEATS);
        idle_wait();

        // Back-to-back requests with rrq held high
        request(28'h0, lat);
        chk("b2b_first_latency", lat, 1);
        ar_phase(0);
        r_phase(BEATS, 0, 0, BEATS, BEATS);
        raddr = 28'h80;
        cnt   = 0;
        while (arvalid !== 1'b1 && cnt < 30) begin
            tick();
            cnt++;
        end
        chk("b2b_gap_min", cnt >= COOL + 1, 1);
        chk("b2b_gap_max", cnt <= COOL + 4, 1);
        chk("b2b_araddr", araddr, 28'h80);
        rrq = 1'b0;
        ar_phase(0);
        r_phase(BEATS, 0, 0, BEATS, BEATS);
        idle_wait();

        // Table-driven scenarios, including response and rlast errors
        for (int r = 0; r < 5; r++) begin
            request(rows[r].addr, lat);
            chk("tbl_latency", lat, 1);
            chk("tbl_arlen", arlen, BEATS - 1);
            rrq = 1'b0;
            ar_phase(rows[r].ar_delay);
            r_phase((rows[r].last_beat != 0) ? rows[r].last_beat : BEATS,
                    rows[r].gap_max, rows[r].err_beat, rows[r].last_beat,
                    rows[r].exp_pulses);
            chk("tbl_err", err, rows[r].exp_err);
            idle_wait();
        end

        // Asynchronous reset in the middle of the data phase
        request(28'h400, lat);
        rrq = 1'b0;
        ar_phase(0);
        for (int b = 1; b <= 8; b++) begin
            rvalid = 1'b1;
            rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rlast  = 1'b0;
            exp_q.push_back(rdata);
            tick();
        end
        rvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_arvalid", arvalid, 0);
        chk("midrst_rsel", rsel, 0);
        chk("midrst_rbusy", rbusy, 0);
        chk("midrst_rready", axi_rready, 0);
        chk("midrst_rdata_rq", rd_rq, 0);
        chk("midrst_err", err, 0);
        chk("midrst_rdata", rd_data, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        request(28'h480, lat);
        chk("post_rst_latency", lat, 1);
        rrq = 1'b0;
        ar_phase(1);
        r_phase(BEATS, 2, 0, BEATS, BEATS);
        chk("post_rst_err", err, 0);
        idle_wait();

`ifdef MBUS_RD_TIMEOUT_EN
        // Stalled data channel trips the watchdog
        request(28'h500, lat);
        rrq = 1'b0;
        ar_phase(0);
        cnt = 0;
        while (rbusy === 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("wd_bound", cnt <= TO + 3, 1);
        chk("wd_err", err, 1);
        chk("wd_rbusy", rbusy, 0);
        chk("wd_strobes", pulses, 0);
        idle_wait();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
